// File: rtl/whirlpool_wcipher_pkg.sv
// Shared constants, types and GF(2^8) helpers for the Whirlpool W-cipher round back-end.
package whirlpool_wcipher_pkg;

    localparam int STATE_W = 512;
    localparam int ROW_W   = 64;
    localparam int BYTE_W  = 8;

    localparam logic [7:0] GF_RED = 8'h1D;

    localparam logic [7:0] THETA_C [8] = '{8'h01, 8'h01, 8'h04, 8'h01,
                                           8'h08, 8'h05, 8'h02, 8'h09};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? GF_RED : 8'h00);
    endfunction

    // Shift-and-add product; with a constant coefficient this folds to a few XORs.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = '0;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Source row of pi: b[r][c] = a[(r-c) mod 8][c]; 3-bit wrap gives the mod.
    function automatic logic [2:0] pi_src_row(input logic [2:0] r, input logic [2:0] c);
        return r - c;
    endfunction

endpackage

// File: rtl/whirlpool_wcipher_theta_row.sv
// Combinational theta (MixRows) for one 64-bit row of the cipher state.
module whirlpool_wcipher_theta_row
    import whirlpool_wcipher_pkg::*;
(
    input  logic [0:ROW_W-1] i_row,
    output logic [0:ROW_W-1] o_row
);

    always_comb begin
        // NOTE: default first, so every bit is assigned on every pass and no latch is inferred.
        o_row = '0;
        for (int j = 0; j < 8; j++) begin
            for (int k = 0; k < 8; k++) begin
                o_row[BYTE_W*j +: BYTE_W] = o_row[BYTE_W*j +: BYTE_W]
                    ^ gf_mul(i_row[BYTE_W*k +: BYTE_W], THETA_C[3'(j - k)]);
            end
        end
    end

endmodule

// File: rtl/whirlpool_wcipher_pi_theta_sigma.sv
// Whirlpool W-cipher round back-end: pi, theta (ROWS_PER_CYCLE rows/clock), optional sigma.
// Define WHIRLPOOL_WCIPHER_SIGMA_EN to register i_key and XOR it into each result row.
module whirlpool_wcipher_pi_theta_sigma
    import whirlpool_wcipher_pkg::*;
#(
    parameter int ROWS_PER_CYCLE = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [0:511]     i_data,
    input  logic [0:511]     i_key,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [0:511]     o_data,
    output logic             o_busy
);

    // With ROWS_PER_CYCLE=8 the step truncates to 0 and the last group starts at row 0.
    localparam logic [2:0] CNT_STEP = 3'(ROWS_PER_CYCLE);
    localparam logic [2:0] CNT_LAST = 3'(8 - ROWS_PER_CYCLE);

    state_e               r_state;
    state_e               w_next;
    logic [2:0]           r_cnt;
    logic [0:STATE_W-1]   r_b;
    logic [0:STATE_W-1]   r_data;
    logic                 r_valid;
    logic                 r_busy;
    logic                 w_accept;
    logic [0:STATE_W-1]   w_pi;

    logic [2:0]           w_idx     [ROWS_PER_CYCLE];
    logic [0:ROW_W-1]     w_row_in  [ROWS_PER_CYCLE];
    logic [0:ROW_W-1]     w_row_out [ROWS_PER_CYCLE];
    logic [0:ROW_W-1]     w_row_res [ROWS_PER_CYCLE];

    for (genvar r = 0; r < 8; r++) begin : g_pi_r
        for (genvar c = 0; c < 8; c++) begin : g_pi_c
            assign w_pi[ROW_W*r + BYTE_W*c +: BYTE_W] =
                i_data[ROW_W*pi_src_row(3'(r), 3'(c)) + BYTE_W*c +: BYTE_W];
        end
    end

`ifdef WHIRLPOOL_WCIPHER_SIGMA_EN
    logic [0:STATE_W-1] r_key;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_key <= '0;
        end else if (w_accept) begin
            r_key <= i_key;
        end
    end
`else
    logic w_unused_key;
    assign w_unused_key = ^i_key;
`endif

    for (genvar g = 0; g < ROWS_PER_CYCLE; g++) begin : g_row
        assign w_idx[g]    = r_cnt + 3'(g);
        assign w_row_in[g] = r_b[ROW_W*w_idx[g] +: ROW_W];

        whirlpool_wcipher_theta_row u_theta (
            .i_row (w_row_in[g]),
            .o_row (w_row_out[g])
        );

`ifdef WHIRLPOOL_WCIPHER_SIGMA_EN
        assign w_row_res[g] = w_row_out[g] ^ r_key[ROW_W*w_idx[g] +: ROW_W];
`else
        assign w_row_res[g] = w_row_out[g];
`endif
    end

    // Registered flags follow the next state so they line up with r_state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            r_state <= w_next;
            r_valid <= (w_next == DONE);
            r_busy  <= (w_next == RUN);
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_next = RUN;
            RUN:     if (r_cnt == CNT_LAST) w_next = DONE;
            DONE:    if (i_ready) w_next = w_accept ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        o_ready = (r_state == IDLE) || ((r_state == DONE) && i_ready);
    end

    assign w_accept = i_valid && o_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: the wide state and result registers are reset too, so no earlier block survives a reset.
            r_b    <= '0;
            r_cnt  <= '0;
            r_data <= '0;
        end else if (w_accept) begin
            r_b   <= w_pi;
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_cnt <= r_cnt + CNT_STEP;
            for (int g = 0; g < ROWS_PER_CYCLE; g++) begin
                r_data[ROW_W*w_idx[g] +: ROW_W] <= w_row_res[g];
            end
        end
    end

    assign o_valid = r_valid;
    assign o_busy  = r_busy;
    assign o_data  = r_data;

endmodule

// File: tb/tb_whirlpool_wcipher_pi_theta_sigma.sv
// Bench for the W-cipher round back-end: four instances (1/2/4/8 rows per clock) with a scoreboard.
module tb_whirlpool_wcipher_pi_theta_sigma;

`ifdef WHIRLPOOL_WCIPHER_SIGMA_EN
    localparam bit SIGMA = 1'b1;
`else
    localparam bit SIGMA = 1'b0;
`endif

    localparam logic [7:0] TC [8] = '{8'h01, 8'h01, 8'h04, 8'h01, 8'h08, 8'h05, 8'h02, 8'h09};

    typedef struct {
        string        name;
        logic [0:511] d;
        logic [0:511] k;
        logic [0:511] exp;
    } vec_t;

    typedef struct {
        int           inst;
        logic [0:511] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   v_in;
    logic [3:0]   rdy_in;
    wire  [3:0]   rdy_out;
    wire  [3:0]   v_out;
    wire  [3:0]   busy_out;
    logic [0:511] d_in  [4];
    logic [0:511] k_in  [4];
    wire  [0:511] d_out [4];

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        whirlpool_wcipher_pi_theta_sigma #(.ROWS_PER_CYCLE(1 << g)) u_dut (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .i_valid (v_in[g]),
            .o_ready (rdy_out[g]),
            .i_data  (d_in[g]),
            .i_key   (k_in[g]),
            .o_valid (v_out[g]),
            .i_ready (rdy_in[g]),
            .o_data  (d_out[g]),
            .o_busy  (busy_out[g])
        );
    end

    task automatic check(input string name, input logic [0:511] act, input logic [0:511] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [8:0] t;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            t = {aa, 1'b0};
            if (t[8]) t = t ^ 9'h11D;
            aa = t[7:0];
        end
        return p;
    endfunction

    function automatic logic [0:511] model(input logic [0:511] a, input logic [0:511] k);
        logic [7:0]   b [8][8];
        logic [7:0]   acc;
        logic [0:511] o;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                b[r][c] = a[64*((r - c + 8) % 8) + 8*c +: 8];
        o = '0;
        for (int r = 0; r < 8; r++) begin
            for (int j = 0; j < 8; j++) begin
                acc = '0;
                for (int m = 0; m < 8; m++) acc = acc ^ gmul(b[r][m], TC[(j - m + 8) % 8]);
                o[64*r + 8*j +: 8] = acc ^ (SIGMA ? k[64*r + 8*j +: 8] : 8'h00);
            end
        end
        return o;
    endfunction

    function automatic logic [0:511] rand512();
        logic [0:511] v;
        for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic accept(input int inst, input logic [0:511] d, input logic [0:511] k,
                          input logic [0:511] exp);
        int t;
        t = 0;
        @(negedge clk);
        v_in[inst] = 1'b1;
        d_in[inst] = d;
        k_in[inst] = k;
        #1;
        while (!rdy_out[inst] && t < 40) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!rdy_out[inst]) fail($sformatf("accept[%0d] o_ready", inst));
        @(posedge clk);
        #1;
        v_in[inst] = 1'b0;
        sb_q.push_back('{inst, exp});
    endtask

    task automatic wait_out(input int inst, input string name, output logic [0:511] exp_o);
        int   cyc;
        exp_t e;
        cyc   = 0;
        exp_o = '0;
        while (!v_out[inst] && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_int({name, " latency"}, cyc, 8 >> inst);
        if (sb_q.size() == 0) begin
            fail({name, " scoreboard"});
        end else begin
            e = sb_q.pop_front();
            check({name, " data"}, d_out[inst], e.data);
            exp_o = e.data;
        end
    endtask

    task automatic drain(input int inst);
        @(negedge clk);
        rdy_in[inst] = 1'b1;
        @(posedge clk);
        #1;
        rdy_in[inst] = 1'b0;
        check_bit($sformatf("drain[%0d] o_valid", inst), v_out[inst], 1'b0);
        check_bit($sformatf("drain[%0d] o_busy", inst), busy_out[inst], 1'b0);
        check_bit($sformatf("drain[%0d] o_ready", inst), rdy_out[inst], 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs [4];
        logic [0:511] d;
        logic [0:511] k;
        logic [0:511] e;

        vecs[0].name = "single_byte";
        vecs[0].d = '0; vecs[0].d[0:7] = 8'h01; vecs[0].k = '0;
        vecs[0].exp = '0; vecs[0].exp[0:63] = 64'h0101040108050209;
        vecs[1].name = "pi_shift";
        vecs[1].d = '0; vecs[1].d[8:15] = 8'h01; vecs[1].k = '0;
        vecs[1].exp = '0; vecs[1].exp[64:127] = 64'h0901010401080502;
        vecs[2].name = "gf_reduce";
        vecs[2].d = '0; vecs[2].d[0:7] = 8'h80; vecs[2].k = '0;
        vecs[2].exp = '0; vecs[2].exp[0:63] = 64'h80803A8074BA1DF4;
        vecs[3].name = "sigma";
        vecs[3].d = '0; vecs[3].k = {512{1'b1}};
        vecs[3].exp = SIGMA ? {512{1'b1}} : '0;

        rst_n  = 1'b0;
        v_in   = '0;
        rdy_in = '0;
        for (int i = 0; i < 4; i++) begin
            d_in[i] = '0;
            k_in[i] = '0;
        end

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check_bit($sformatf("reset[%0d] o_ready", i), rdy_out[i], 1'b1);
            check_bit($sformatf("reset[%0d] o_valid", i), v_out[i], 1'b0);
            check_bit($sformatf("reset[%0d] o_busy", i), busy_out[i], 1'b0);
            check($sformatf("reset[%0d] o_data", i), d_out[i], '0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            accept(0, vecs[i].d, vecs[i].k, vecs[i].exp);
            wait_out(0, vecs[i].name, e);
            drain(0);
        end

        for (int g = 0; g < 4; g++) begin
            d = rand512();
            k = rand512();
            accept(g, d, k, model(d, k));
            wait_out(g, $sformatf("rand[%0d]", g), e);
            repeat (5) begin
                @(posedge clk);
                #1;
                check_bit($sformatf("stall[%0d] o_valid", g), v_out[g], 1'b1);
                check($sformatf("stall[%0d] o_data", g), d_out[g], e);
                check_bit($sformatf("stall[%0d] o_ready", g), rdy_out[g], 1'b0);
            end
            d = rand512();
            k = rand512();
            @(negedge clk);
            rdy_in[g] = 1'b1;
            v_in[g]   = 1'b1;
            d_in[g]   = d;
            k_in[g]   = k;
            #1;
            check_bit($sformatf("b2b[%0d] o_ready", g), rdy_out[g], 1'b1);
            @(posedge clk);
            #1;
            rdy_in[g] = 1'b0;
            v_in[g]   = 1'b0;
            sb_q.push_back('{g, model(d, k)});
            check_bit($sformatf("b2b[%0d] o_valid low", g), v_out[g], 1'b0);
            check_bit($sformatf("b2b[%0d] o_busy", g), busy_out[g], 1'b1);
            wait_out(g, $sformatf("b2b[%0d]", g), e);
            drain(g);
        end

        d = rand512();
        k = rand512();
        accept(0, d, k, model(d, k));
        repeat (2) @(posedge clk);
        #1;
        check_bit("midrun o_busy", busy_out[0], 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_bit("midrun_rst o_valid", v_out[0], 1'b0);
        check_bit("midrun_rst o_busy", busy_out[0], 1'b0);
        check("midrun_rst o_data", d_out[0], '0);
        check_bit("midrun_rst o_ready", rdy_out[0], 1'b1);
        void'(sb_q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        d = rand512();
        k = rand512();
        accept(0, d, k, model(d, k));
        wait_out(0, "after_rst", e);
        drain(0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
